// File: rtl/vector_dmem_responder_if.sv
// ---------------------------------------------------------------------------
// vector_dmem_responder_if
//   RAM request/response bundle between the SIMD processor (master) and the
//   vector data-memory responder (slave).
//
//   address_RAM    word address of the request
//   byteena_RAM    per-byte write enables, bit i covers data bits 8i+7:8i
//   writeData_RAM  write data
//   rden_RAM       read request, sampled each rising edge
//   wren_RAM       write request, sampled each rising edge
//   readData_RAM   read data, held between responses
//   rvalid_RAM     one-cycle strobe qualifying readData_RAM
//   oob_err        one-cycle pulse for an out-of-range access
//   oob_sticky     latched out-of-range flag, cleared only by reset
// ---------------------------------------------------------------------------
interface vector_dmem_responder_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 256
);
    logic [ADDR_W-1:0]   address_RAM;
    logic [DATA_W/8-1:0] byteena_RAM;
    logic [DATA_W-1:0]   writeData_RAM;
    logic                rden_RAM;
    logic                wren_RAM;
    logic [DATA_W-1:0]   readData_RAM;
    logic                rvalid_RAM;
    logic                oob_err;
    logic                oob_sticky;

    modport master (
        output address_RAM, byteena_RAM, writeData_RAM, rden_RAM, wren_RAM,
        input  readData_RAM, rvalid_RAM, oob_err, oob_sticky
    );

    modport slave (
        input  address_RAM, byteena_RAM, writeData_RAM, rden_RAM, wren_RAM,
        output readData_RAM, rvalid_RAM, oob_err, oob_sticky
    );
endinterface

// File: rtl/vector_dmem_responder.sv
// ---------------------------------------------------------------------------
// vector_dmem_responder
//   Target end of the SIMD processor's vector RAM port. Serves byte-enabled
//   256-bit word writes and fixed-latency pipelined reads from an internal
//   DEPTH-word array. Accesses at address >= DEPTH never touch the array:
//   writes are dropped, reads return zero, and both raise oob_err/oob_sticky.
//
//   Ports:
//     clk    system clock, rising edge
//     reset  asynchronous active-low reset (clears pipeline and flags,
//            never the array contents)
//     bus    vector_dmem_responder_if.slave request/response bundle
//     rd_count, wr_count  (only with DMEM_STATS_EN) saturating 32-bit
//            counters of accepted reads / effective in-range writes
//
//   Parameters: ADDR_W, DATA_W (multiple of 8), DEPTH,
//               READ_LATENCY (1..4, accept edge to data-valid edge count)
//
//   Optional feature macro: DMEM_STATS_EN
// ---------------------------------------------------------------------------
module vector_dmem_responder #(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 256,
    parameter int DEPTH        = 1024,
    parameter int READ_LATENCY = 2
) (
    input  logic clk,
    input  logic reset,
    vector_dmem_responder_if.slave bus
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
`endif
);
    localparam int              BE_W      = DATA_W / 8;
    localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] rd_word;
    logic              wr_accept;

    // NOTE: every combinational output gets a default before any condition,
    // so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        in_range  = ({1'b0, bus.address_RAM} < DEPTH_EXT);
        idx       = '0;
        rd_word   = '0;
        wr_accept = 1'b0;
        // The index is only derived once the range check has passed, so an
        // out-of-range address can never alias onto a low word.
        if (in_range) begin
            idx       = bus.address_RAM[IDX_W-1:0];
            rd_word   = mem[idx];
            wr_accept = bus.wren_RAM;
        end
    end

    // NOTE: the array is deliberately left out of the reset branch; clearing
    // DEPTH x DATA_W bits would prevent RAM mapping and reset contents are
    // undefined anyway. Holding reset still blocks a write on that edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // array contents are left untouched
        end else if (wr_accept) begin
            for (int i = 0; i < BE_W; i++) begin
                if (bus.byteena_RAM[i]) begin
                    mem[idx][8*i +: 8] <= bus.writeData_RAM[8*i +: 8];
                end
            end
        end
    end

    // Read pipeline: stage 0 captures the pre-write array word on the accept
    // edge (read-first); the last stage is the visible response.
    logic [DATA_W-1:0]       pipe_data [READ_LATENCY];
    logic [READ_LATENCY-1:0] pipe_valid;
    logic [READ_LATENCY-1:0] pipe_oob;
    logic                    wr_err_q;
    logic                    sticky_q;

    // NOTE: state registers use non-blocking assignments only, so every
    // stage samples its predecessor's value from before this edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < READ_LATENCY; k++) begin
                pipe_data[k] <= '0;
            end
            pipe_valid <= '0;
            pipe_oob   <= '0;
            wr_err_q   <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            pipe_valid[0] <= bus.rden_RAM;
            pipe_oob[0]   <= bus.rden_RAM && !in_range;
            if (bus.rden_RAM) begin
                pipe_data[0] <= rd_word;
            end
            // Data only advances behind a valid bit, which keeps the output
            // word stable between responses.
            for (int k = 1; k < READ_LATENCY; k++) begin
                pipe_valid[k] <= pipe_valid[k-1];
                pipe_oob[k]   <= pipe_oob[k-1];
                if (pipe_valid[k-1]) begin
                    pipe_data[k] <= pipe_data[k-1];
                end
            end
            // A bad write shares its address with any same-edge read, so that
            // read is bad too and its response carries the single pulse.
            wr_err_q <= bus.wren_RAM && !in_range && !bus.rden_RAM;
            sticky_q <= bus.oob_sticky;
        end
    end

    assign bus.readData_RAM = pipe_data[READ_LATENCY-1];
    assign bus.rvalid_RAM   = pipe_valid[READ_LATENCY-1];
    assign bus.oob_err      = pipe_oob[READ_LATENCY-1] | wr_err_q;
    assign bus.oob_sticky   = sticky_q | bus.oob_err;

`ifdef DMEM_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (bus.rden_RAM && (rd_count != 32'hFFFF_FFFF)) begin
                rd_count <= rd_count + 32'd1;
            end
            if (wr_accept && (|bus.byteena_RAM) && (wr_count != 32'hFFFF_FFFF)) begin
                wr_count <= wr_count + 32'd1;
            end
        end
    end
`endif

endmodule
